dircc_avalon_st_packet_sender: RTL and testbench
================================================

// Module: dircc_avalon_st_packet_sender
// PURPOSE
//  Serialises one packet_t (dircc_types_pkg) into an 8-word Avalon-ST packet on a 32-bit source.
//  It is the transmit-side counterpart to the Avalon-ST packet receiver and uses identical word order.
//  It sits between the node/softcore send path and the fabric router.
//  The local side hands over a whole packet in one beat; the block streams it out with full backpressure support.
// PARAMETERS
//  DATA_WIDTH        32  Avalon-ST symbol-group width. Only 32 is supported.
//  EMPTY_WIDTH       2   Width of out_empty.
//  WORDS_PER_PACKET  8   Beats per packet. Fixed at 8; any other value is an elaboration error.
// PORTS
//  clk                 in   1    Single clock.
//  reset_n             in   1    Synchronous, active-low reset.
//  packet_data         in   256  packet_t to send. Sampled only on the accept cycle.
//  send_valid          in   1    Local request to send packet_data.
//  send_ready          out  1    Block is idle and can accept a packet.
//  send_nearly_done    out  1    Final beat (word 7) is presented but not yet accepted.
//  send_done           out  1    1-cycle pulse after word 7 is accepted.
//  out_data            out  32   Avalon-ST source data.
//  out_valid           out  1    Avalon-ST source valid.
//  out_ready           in   1    Avalon-ST sink ready (readyLatency = 0).
//  out_startofpacket   out  1    High on word 0 only.
//  out_endofpacket     out  1    High on word 7 only.
//  out_empty           out  2    Always 0.
// BEHAVIOUR
//  Clocking and reset
//  - One clock. Reset is synchronous and active-low.
//  - Reset values: send_ready=1; send_nearly_done=0; send_done=0; out_valid=0; sop=0; eop=0; out_empty=0; out_data=0.
//  - Internal state on reset: word index=0, state=IDLE.
//  FSM: IDLE, SEND
//  - IDLE: send_ready=1. If send_valid=1, register packet_data, set idx=0 and go to SEND.
//  - An accepted packet drives out_valid=1 with word 0 in the next cycle (1-cycle latency).
//  - SEND: send_ready=0. A beat transfers when out_valid & out_ready.
//    - Not last beat: idx++.
//    - Beat at idx 7: out_valid=0 next cycle, send_done=1 for exactly 1 cycle, return to IDLE.
//    - send_ready rises together with send_done.
//  - Minimum occupancy is 1 accept cycle + 8 beat cycles. There is no back-to-back overlap:
//    the next packet is accepted no earlier than the send_done cycle.
//  Word mapping (idx -> out_data)
//  - 0: dest_addr.hw_addr (sop=1)
//  - 1: {dest_addr.sw_addr[15:0], dest_addr.port[6:0], dest_addr.flag, 8'b0}
//  - 2: src_addr.hw_addr
//  - 3: {src_addr.sw_addr, src_addr.port, src_addr.flag, 8'b0}
//  - 4: lamport
//  - 5: data[31:0]
//  - 6: data[63:32]
//  - 7: data[95:64] (eop=1)
//  Avalon-ST rules
//  - While out_valid=1 and out_ready=0, out_data, sop, eop and out_empty hold stable. out_valid never drops before transfer.
//  - out_ready is ignored when out_valid=0.
//  Local-side rules
//  - send_valid in SEND is ignored. The packet is not queued and the captured packet is not modified.
//  - Changing packet_data after the accept cycle has no effect on the packet in flight.
//  - send_nearly_done = (state==SEND) & (idx==7) & out_valid. It is combinational from registered state.
//  Boundary cases
//  - out_ready held low indefinitely: the block stalls with no timeout and the word is held.
//  - Reset mid-packet: at the next edge out_valid=0 and the FSM is IDLE. The partial packet is dropped with no eop.
//    The sink is responsible for discarding it on the next sop.
//  - send_valid=1 in the same cycle reset_n=0: reset wins and nothing is captured.
// TESTING
//  - Reset check: hold reset_n=0 for 10 clk, release, wait 10 clk.
//    -> send_ready=1, out_valid=0, send_done=0, send_nearly_done=0.
//  - Single packet, out_ready=1: send dest.hw=32'h0000_0011, src.hw=32'h0000_0022, lamport=5, data=96'h3_0000_0002_0000_0001.
//    -> exactly 8 consecutive beats, data 11, {sw,port,flag,8'h00}, 22, ..., 5, 1, 2, 3.
//    -> sop only on beat 0, eop only on beat 7, empty=0 on every beat.
//    -> send_done pulses 1 cycle after beat 7.
//  - Backpressure: out_ready toggles 1,0,0,1... pseudo-randomly.
//    -> every stalled beat is held bit-stable.
//    -> the received packet equals the sent one (field-by-field compare).
//    -> no duplicated or dropped beats.
//  - Busy rejection: pulse send_valid with a second packet at beat 3 of the first.
//    -> the first packet completes unchanged; no second packet appears; send_ready stays 0 until send_done.
//  - Back-to-back: hold send_valid=1 with packets lamport=0 then lamport=1.
//    -> two complete 8-beat packets in order, separated by exactly 1 idle cycle (out_valid=0).
//  - Reset mid-packet: assert reset_n=0 after beat 4.
//    -> out_valid=0 at the next edge, no eop emitted, send_ready=1 after release.
//    -> a fresh packet then sends correctly.

Source files
------------

// File: rtl/dircc_avalon_st_packet_sender.sv
// Shared dircc packet types, and the Avalon-ST sender that serialises one
// packet_t into eight 32-bit beats with full source-side backpressure.
package dircc_types_pkg;

  typedef struct packed {
    logic [31:0] hw_addr;
    logic [15:0] sw_addr;
    logic [6:0]  port;
    logic        flag;
  } address_t;

  typedef struct packed {
    logic [15:0] reserved;
    address_t    dest_addr;
    address_t    src_addr;
    logic [31:0] lamport;
    logic [95:0] data;
  } packet_t;

endpackage

module dircc_avalon_st_packet_sender
  import dircc_types_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned EMPTY_WIDTH      = 2,
  parameter int unsigned WORDS_PER_PACKET = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  packet_t                packet_data,
  input  logic                   send_valid,
  output logic                   send_ready,
  output logic                   send_nearly_done,
  output logic                   send_done,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_startofpacket,
  output logic                   out_endofpacket,
  output logic [EMPTY_WIDTH-1:0] out_empty
);

  localparam int unsigned IDX_W = $clog2(WORDS_PER_PACKET);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_PACKET - 1);

  // The word map below is hard-wired to eight 32-bit beats.
  if (DATA_WIDTH != 32 || WORDS_PER_PACKET != 8) begin : g_param_check
    $error("dircc_avalon_st_packet_sender: only DATA_WIDTH=32 and WORDS_PER_PACKET=8 are supported");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  packet_t               pkt_q, pkt_d;
  logic                  valid_d;
  logic                  done_d;
  logic                  sop_d;
  logic                  eop_d;
  logic [DATA_WIDTH-1:0] data_d;

  // Beat index to wire word, same order the receiver reassembles in.
  function automatic logic [31:0] word_sel(input packet_t p, input logic [IDX_W-1:0] i);
    logic [31:0] w;
    case (i)
      IDX_W'(0): w = p.dest_addr.hw_addr;
      IDX_W'(1): w = {p.dest_addr.sw_addr, p.dest_addr.port, p.dest_addr.flag, 8'h00};
      IDX_W'(2): w = p.src_addr.hw_addr;
      IDX_W'(3): w = {p.src_addr.sw_addr, p.src_addr.port, p.src_addr.flag, 8'h00};
      IDX_W'(4): w = p.lamport;
      IDX_W'(5): w = p.data[31:0];
      IDX_W'(6): w = p.data[63:32];
      default:   w = p.data[95:64];
    endcase
    return w;
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pkt_d   = pkt_q;
    valid_d = out_valid;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (send_valid) begin
          pkt_d   = packet_data;
          idx_d   = '0;
          state_d = SEND;
          valid_d = 1'b1;
        end
      end
      SEND: begin
        if (out_valid && out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        valid_d = 1'b0;
      end
    endcase

    // Output word/framing follow the next index, so they only move on a transfer.
    data_d = valid_d ? DATA_WIDTH'(word_sel(pkt_d, idx_d)) : '0;
    sop_d  = valid_d && (idx_d == '0);
    eop_d  = valid_d && (idx_d == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q           <= IDLE;
      idx_q             <= '0;
      pkt_q             <= '0;
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      send_ready        <= 1'b1;
      send_done         <= 1'b0;
    end else begin
      state_q           <= state_d;
      idx_q             <= idx_d;
      pkt_q             <= pkt_d;
      out_valid         <= valid_d;
      out_data          <= data_d;
      out_startofpacket <= sop_d;
      out_endofpacket   <= eop_d;
      send_ready        <= (state_d == IDLE);
      send_done         <= done_d;
    end
  end

  assign send_nearly_done = (state_q == SEND) && (idx_q == LAST_IDX) && out_valid;
  assign out_empty        = '0;

endmodule

// File: tb/tb_dircc_avalon_st_packet_sender.sv
// Bench for dircc_avalon_st_packet_sender: scoreboard of expected beats,
// checked by a sink monitor, driven by one task per scenario.
module tb_dircc_avalon_st_packet_sender;
  import dircc_types_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  packet_t     packet_data = '0;
  logic        send_valid = 1'b0;
  logic        send_ready;
  logic        send_nearly_done;
  logic        send_done;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_startofpacket;
  logic        out_endofpacket;
  logic [1:0]  out_empty;

  int errors = 0;
  int checks = 0;

  logic [31:0] sb[$];
  int          beat_idx = 0;
  bit          done_pending = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_data;
  logic        prev_sop, prev_eop;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          last_sop_cyc = -1000;
  int          last_eop_cyc = -1000;
  int          sop_gap = -1;
  bit          bp_en = 0;

  dircc_avalon_st_packet_sender dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .packet_data       (packet_data),
    .send_valid        (send_valid),
    .send_ready        (send_ready),
    .send_nearly_done  (send_nearly_done),
    .send_done         (send_done),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_empty         (out_empty)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

  // Pseudo-random sink backpressure when enabled.
  initial forever begin
    @(posedge clk); #1;
    if (bp_en) out_ready = 1'($urandom_range(0, 1));
  end

  function automatic logic [31:0] model_word(input packet_t p, input int i);
    case (i)
      0: return p.dest_addr.hw_addr;
      1: return {p.dest_addr.sw_addr, p.dest_addr.port, p.dest_addr.flag, 8'h00};
      2: return p.src_addr.hw_addr;
      3: return {p.src_addr.sw_addr, p.src_addr.port, p.src_addr.flag, 8'h00};
      4: return p.lamport;
      5: return p.data[31:0];
      6: return p.data[63:32];
      default: return p.data[95:64];
    endcase
  endfunction

  function automatic packet_t rand_pkt(input logic [31:0] lam);
    packet_t p;
    p.reserved          = 16'($urandom);
    p.dest_addr.hw_addr = $urandom;
    p.dest_addr.sw_addr = 16'($urandom);
    p.dest_addr.port    = 7'($urandom);
    p.dest_addr.flag    = 1'($urandom);
    p.src_addr.hw_addr  = $urandom;
    p.src_addr.sw_addr  = 16'($urandom);
    p.src_addr.port     = 7'($urandom);
    p.src_addr.flag     = 1'($urandom);
    p.lamport           = lam;
    p.data              = {$urandom, $urandom, $urandom};
    return p;
  endfunction

  // Sink monitor: pops the scoreboard on every transfer and checks framing.
  initial forever begin
    logic [31:0] exp_w;
    @(negedge clk);
    if (!reset_n) begin
      beat_idx = 0; done_pending = 0; prev_stall = 0;
    end else begin
      checks++;
      if (send_done !== done_pending) begin
        errors++;
        $display("FAIL send_done_pulse: got %b required %b at cycle %0d", send_done, done_pending, cyc);
      end
      done_pending = 0;
      checks++;
      if (send_nearly_done !== (out_valid && beat_idx == 7)) begin
        errors++;
        $display("FAIL nearly_done: got %b required %b at cycle %0d", send_nearly_done,
                 (out_valid && beat_idx == 7), cyc);
      end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data || out_startofpacket !== prev_sop ||
            out_endofpacket !== prev_eop) begin
          errors++;
          $display("FAIL stall_hold: got v=%b d=%h s=%b e=%b required v=1 d=%h s=%b e=%b",
                   out_valid, out_data, out_startofpacket, out_endofpacket, prev_data, prev_sop, prev_eop);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got data %h with empty scoreboard, required no beat", out_data);
        end else begin
          exp_w = sb.pop_front();
          if (out_data !== exp_w || out_startofpacket !== (beat_idx == 0) ||
              out_endofpacket !== (beat_idx == 7) || out_empty !== 2'b00) begin
            errors++;
            $display("FAIL beat%0d: got d=%h s=%b e=%b m=%0d required d=%h s=%b e=%b m=0", beat_idx,
                     out_data, out_startofpacket, out_endofpacket, out_empty, exp_w,
                     (beat_idx == 0), (beat_idx == 7));
          end
        end
        if (beat_idx == 0) begin
          sop_gap = cyc - last_eop_cyc;
          last_sop_cyc = cyc;
        end
        if (beat_idx == 7) begin
          done_pending = 1; beat_idx = 0; last_eop_cyc = cyc;
        end else begin
          beat_idx++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_sop   = out_startofpacket;
      prev_eop   = out_endofpacket;
    end
  end

  task automatic push_model(input packet_t p);
    for (int i = 0; i < 8; i++) sb.push_back(model_word(p, i));
  endtask

  task automatic send_pkt(input packet_t p);
    bit ok = 0;
    for (int n = 0; n < 500 && !ok; n++) begin
      @(negedge clk); #1;
      if (send_ready) ok = 1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_accept_timeout: send_ready=%b required 1", send_ready);
    end else begin
      acc_cyc = cyc;
      packet_data = p;
      send_valid = 1'b1;
      @(posedge clk); #1;
      send_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(negedge clk); #1;
      if (sb.size() == 0 && send_ready && !out_valid) ok = 1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_drain: %0d beats outstanding, send_ready=%b, required 0 and 1", name, sb.size(), send_ready);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    send_valid = 1'b1;
    packet_data = rand_pkt(32'd7);
    repeat (10) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_wins: out_valid=%b required 0", out_valid);
    end
    send_valid = 1'b0;
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (send_ready !== 1'b1) begin errors++; $display("FAIL reset_send_ready: got %b required 1", send_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    checks++;
    if (send_done !== 1'b0) begin errors++; $display("FAIL reset_send_done: got %b required 0", send_done); end
    checks++;
    if (send_nearly_done !== 1'b0) begin
      errors++; $display("FAIL reset_nearly_done: got %b required 0", send_nearly_done);
    end
    checks++;
    if (out_data !== 32'h0 || out_startofpacket !== 1'b0 || out_endofpacket !== 1'b0 || out_empty !== 2'b00) begin
      errors++;
      $display("FAIL reset_outputs: got d=%h s=%b e=%b m=%0d required all 0", out_data, out_startofpacket,
               out_endofpacket, out_empty);
    end
  endtask

  task automatic test_single_packet();
    packet_t p;
    p = '0;
    p.dest_addr.hw_addr = 32'h0000_0011;
    p.dest_addr.sw_addr = 16'hABCD;
    p.dest_addr.port    = 7'h55;
    p.dest_addr.flag    = 1'b1;
    p.src_addr.hw_addr  = 32'h0000_0022;
    p.src_addr.sw_addr  = 16'h1234;
    p.src_addr.port     = 7'h12;
    p.src_addr.flag     = 1'b0;
    p.lamport           = 32'd5;
    p.data              = 96'h3_0000_0002_0000_0001;
    out_ready = 1'b1;
    sb.push_back(32'h0000_0011);
    sb.push_back(32'hABCD_AB00);
    sb.push_back(32'h0000_0022);
    sb.push_back(32'h1234_2400);
    sb.push_back(32'h0000_0005);
    sb.push_back(32'h0000_0001);
    sb.push_back(32'h0000_0002);
    sb.push_back(32'h0000_0003);
    send_pkt(p);
    wait_idle("single");
    checks++;
    if (last_sop_cyc !== acc_cyc + 1) begin
      errors++; $display("FAIL single_latency: sop at cycle %0d required %0d", last_sop_cyc, acc_cyc + 1);
    end
    checks++;
    if (last_eop_cyc - last_sop_cyc !== 7) begin
      errors++; $display("FAIL single_consecutive: eop-sop=%0d required 7", last_eop_cyc - last_sop_cyc);
    end
  endtask

  task automatic test_backpressure();
    packet_t p;
    p = rand_pkt(32'd100);
    out_ready = 1'b0;
    send_pkt(p);
    push_model(p);
    repeat (30) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_startofpacket !== 1'b1 || out_data !== model_word(p, 0)) begin
      errors++;
      $display("FAIL long_stall: got v=%b s=%b d=%h required v=1 s=1 d=%h", out_valid, out_startofpacket,
               out_data, model_word(p, 0));
    end
    bp_en = 1;
    for (int k = 0; k < 4; k++) begin
      p = rand_pkt(32'(200 + k));
      send_pkt(p);
      push_model(p);
    end
    wait_idle("backpressure");
    bp_en = 0;
    out_ready = 1'b1;
  endtask

  task automatic test_busy_reject();
    packet_t p1, p2;
    bit hit = 0, seen_done = 0, stray = 0;
    int early = 0;
    p1 = rand_pkt(32'd300);
    p2 = rand_pkt(32'd301);
    out_ready = 1'b1;
    send_pkt(p1);
    push_model(p1);
    for (int n = 0; n < 100 && !hit; n++) begin
      @(negedge clk); #1;
      if (beat_idx == 3) hit = 1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL busy_reach_beat3: beat index %0d required 3", beat_idx); end
    checks++;
    if (send_ready !== 1'b0) begin errors++; $display("FAIL busy_ready_low: got %b required 0", send_ready); end
    packet_data = p2;
    send_valid = 1'b1;
    @(posedge clk); #1;
    send_valid = 1'b0;
    for (int n = 0; n < 100 && !seen_done; n++) begin
      @(negedge clk); #1;
      if (send_done) begin
        seen_done = 1;
        checks++;
        if (send_ready !== 1'b1) begin
          errors++; $display("FAIL busy_ready_with_done: got %b required 1", send_ready);
        end
      end else if (send_ready) begin
        early++;
      end
    end
    checks++;
    if (!seen_done || early != 0) begin
      errors++; $display("FAIL busy_done: done_seen=%b early_ready=%0d required 1 and 0", seen_done, early);
    end
    repeat (20) begin
      @(negedge clk); #1;
      if (out_valid) stray = 1;
    end
    checks++;
    if (stray || sb.size() != 0) begin
      errors++; $display("FAIL busy_no_second: stray=%b outstanding=%0d required 0 and 0", stray, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    packet_t pa, pb;
    bit ok = 0;
    pa = rand_pkt(32'd0);
    pb = rand_pkt(32'd1);
    out_ready = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk); #1;
      if (send_ready) ok = 1;
    end
    packet_data = pa;
    send_valid = 1'b1;
    @(posedge clk);
    push_model(pa);
    #1;
    packet_data = pb;
    ok = 0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk); #1;
      if (send_ready) ok = 1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_second_ready: send_ready=%b required 1", send_ready); end
    @(posedge clk);
    push_model(pb);
    #1;
    send_valid = 1'b0;
    packet_data = rand_pkt(32'hDEAD);
    wait_idle("b2b");
    checks++;
    if (sop_gap !== 2) begin
      errors++; $display("FAIL b2b_gap: sop-eop distance %0d required 2", sop_gap);
    end
  endtask

  task automatic test_reset_mid_packet();
    packet_t p;
    bit hit = 0;
    p = rand_pkt(32'd400);
    out_ready = 1'b1;
    send_pkt(p);
    push_model(p);
    for (int n = 0; n < 100 && !hit; n++) begin
      @(negedge clk); #1;
      if (beat_idx == 5) hit = 1;
    end
    reset_n = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || out_endofpacket !== 1'b0) begin
      errors++; $display("FAIL mid_reset_drop: v=%b e=%b required 0 0", out_valid, out_endofpacket);
    end
    sb.delete();
    repeat (2) @(negedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (send_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset_idle: ready=%b v=%b required 1 0", send_ready, out_valid);
    end
    p = rand_pkt(32'd401);
    send_pkt(p);
    push_model(p);
    wait_idle("after_reset");
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_backpressure();
    test_busy_reject();
    test_back_to_back();
    test_reset_mid_packet();
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
